// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER single-memory arbiter.
package otter_arb_pkg;
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic PORT_IF     = 1'b0;
    localparam logic PORT_D      = 1'b1;
    localparam int   TIMEOUT_DEF = 255;
endpackage

// File: rtl/Mult2to1.sv
// Generic 2:1 multiplexer; Sel=0 passes In1, Sel=1 passes In2.
module Mult2to1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             Sel,
    output logic [WIDTH-1:0] Out
);
    assign Out = Sel ? In2 : In1;
endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares one multi-cycle memory port between fetch (IF) and data (D) requesters.
// Define OTTER_ARB_RR_EN for round-robin arbitration; default is fixed D-over-IF.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic [DATA_W-1:0] IF_RDATA,
    output logic              IF_ACK,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [3:0]        D_BE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              D_ACK,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [3:0]        MEM_BE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_ACK,
    output logic              GNT_SEL,
    output logic              BUSY,
    output logic              ERR
);
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

    state_t                   r_state, w_next;
    logic                     r_gnt, r_we, r_err;
    logic [3:0]               r_be;
    logic [ADDR_W-1:0]        r_addr;
    logic [DATA_W-1:0]        r_wdata;
    logic [7:0]               r_cnt;
    logic                     w_any, w_win, w_grant, w_wait;
    logic                     w_timeout, w_mem_ok, w_done, w_to_ack;
    logic [ADDR_W+DATA_W-1:0] w_steer;

    assign w_any  = IF_REQ | D_REQ;
    assign w_wait = (r_state == WAIT);

`ifdef OTTER_ARB_RR_EN
    logic r_last;

    // On a tie the port that did not win the previous grant goes first.
    assign w_win = (IF_REQ & D_REQ) ? ~r_last : D_REQ;

    always_ff @(posedge CLK) begin
        if (RST)
            r_last <= PORT_D;
        else if (w_grant)
            r_last <= w_win;
    end
`else
    assign w_win = D_REQ ? PORT_D : PORT_IF;
`endif

    // Fetch carries no write data, so its lower half is zero-filled.
    Mult2to1 #(.WIDTH(ADDR_W + DATA_W)) u_steer (
        .In1 ({IF_ADDR, {DATA_W{1'b0}}}),
        .In2 ({D_ADDR, D_WDATA}),
        .Sel (w_win),
        .Out (w_steer)
    );

    // A real ack beats a coincident timeout; reset suppresses any completion.
    assign w_timeout = w_wait && (r_cnt == TO_LIM);
    assign w_mem_ok  = w_wait && MEM_ACK && !RST;
    assign w_done    = w_wait && (MEM_ACK || w_timeout) && !RST;
    assign w_to_ack  = w_done && !MEM_ACK;

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            IDLE: if (w_any) begin
                w_next  = WAIT;
                w_grant = 1'b1;
            end
            WAIT: if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_gnt   <= PORT_IF;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_gnt             <= w_win;
                r_we              <= (w_win == PORT_D) ? D_WE : 1'b0;
                r_be              <= (w_win == PORT_D) ? D_BE : 4'hF;
                {r_addr, r_wdata} <= w_steer;
                r_cnt             <= 8'h00;
            end else if (w_wait && r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'h01;
            end
            if (w_to_ack)
                r_err <= 1'b1;
        end
    end

    assign MEM_REQ   = w_wait;
    assign MEM_WE    = w_wait & r_we;
    assign MEM_BE    = w_wait ? r_be    : 4'h0;
    assign MEM_ADDR  = w_wait ? r_addr  : '0;
    assign MEM_WDATA = w_wait ? r_wdata : '0;
    assign BUSY      = w_wait;
    assign GNT_SEL   = r_gnt;
    assign ERR       = r_err;
    assign IF_ACK    = w_done && (r_gnt == PORT_IF);
    assign D_ACK     = w_done && (r_gnt == PORT_D);
    assign IF_RDATA  = w_mem_ok ? MEM_RDATA : '0;
    assign D_RDATA   = w_mem_ok ? MEM_RDATA : '0;
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Randomized self-checking bench for otter_mem_arbiter with a transaction-level model.
module tb_otter_mem_arbiter;
    localparam int TO = 4;

    logic        CLK = 1'b0, RST = 1'b1;
    logic        IF_REQ = 0, IF_ACK, D_REQ = 0, D_WE = 0, D_ACK;
    logic [31:0] IF_ADDR = 0, IF_RDATA, D_ADDR = 0, D_WDATA = 0, D_RDATA;
    logic [3:0]  D_BE = 0, MEM_BE;
    logic        MEM_REQ, MEM_WE, MEM_ACK = 0, GNT_SEL, BUSY, ERR;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA = 0;

    always #5 CLK = ~CLK;

    otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RST(RST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_ACK(IF_ACK),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_RDATA(D_RDATA), .D_ACK(D_ACK),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
        .GNT_SEL(GNT_SEL), .BUSY(BUSY), .ERR(ERR)
    );

    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;
    typedef struct { bit owner; logic [31:0] rdata; int wc; } ack_t;

    req_t if_q[$], d_q[$];
    ack_t ack_log[$];
    bit   grant_log[$];
    bit   last_win = 1'b1;
    bit   err_exp  = 1'b0;
    int   vecs = 0, errs = 0;

    // Arbitration rule: fixed D-over-IF, or alternate on ties when round-robin.
    function automatic bit arb(input bit ir, input bit dr);
`ifdef OTTER_ARB_RR_EN
        if (ir && dr) return ~last_win;
`endif
        return dr;
    endfunction

    task automatic drive_reqs();
        IF_REQ = (if_q.size() != 0);
        IF_ADDR = 32'h0;
        if (if_q.size() != 0) IF_ADDR = if_q[0].addr;
        D_REQ = (d_q.size() != 0);
        {D_WE, D_BE, D_ADDR, D_WDATA} = '0;
        if (d_q.size() != 0) begin
            D_WE = d_q[0].we; D_BE = d_q[0].be; D_ADDR = d_q[0].addr; D_WDATA = d_q[0].wdata;
        end
    endtask

    task automatic push_if(input logic [31:0] a);
        req_t r;
        r.addr = a; r.we = 1'b0; r.be = 4'hF; r.wdata = 32'h0;
        if_q.push_back(r);
    endtask

    task automatic push_d(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
        req_t r;
        r.addr = a; r.we = we; r.be = be; r.wdata = wd;
        d_q.push_back(r);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1; IF_REQ = 0; D_REQ = 0; MEM_ACK = 0;
        @(posedge CLK); #1;
        RST = 1'b0;
        last_win = 1'b1; err_exp = 1'b0;
        if_q.delete(); d_q.delete(); ack_log.delete(); grant_log.delete();
    endtask

    // Requesters drain their queues; memory acks after lat_sel cycles (-1 random, 99 never).
    task automatic run(input int max_cyc, input int lat_sel, input int gen_pct, input int gen_cyc,
                       input bit fix_en, input logic [31:0] fix_rd);
        bit busy_exp, owner, mack, to_now, done, finished, ir, dr;
        int wc, lat;
        logic [31:0] rd, rexp;
        req_t fr;
        busy_exp = 0; owner = 0; wc = 0; lat = 0; finished = 0;
        for (int idx = 0; idx < max_cyc && !finished; idx++) begin
            @(posedge CLK); #1;
            vecs++; if (MEM_REQ !== busy_exp || BUSY !== busy_exp)
                begin errs++; $display("FAIL busy: MEM_REQ=%0b BUSY=%0b expected %0b", MEM_REQ, BUSY, busy_exp); end
            vecs++; if (ERR !== err_exp)
                begin errs++; $display("FAIL err: got %0b expected %0b", ERR, err_exp); end
            if (busy_exp && wc == 0) begin
                vecs++; if (GNT_SEL !== owner)
                    begin errs++; $display("FAIL gnt_sel: got %0b expected %0b", GNT_SEL, owner); end
                grant_log.push_back(owner);
                lat = (lat_sel < 0) ? int'($urandom_range(0, 3)) : lat_sel;
            end
            if (busy_exp) begin
                wc++;
                if ((owner ? d_q.size() : if_q.size()) == 0) begin
                    errs++; vecs++; $display("FAIL owner_q: no request held by owner %0b", owner);
                end else begin
                    fr = owner ? d_q[0] : if_q[0];
                    vecs++; if (MEM_ADDR !== fr.addr || MEM_WE !== fr.we || MEM_BE !== fr.be ||
                                (owner && MEM_WDATA !== fr.wdata))
                        begin errs++; $display("FAIL mem_fields: got a=%h we=%0b be=%h wd=%h expected a=%h we=%0b be=%h wd=%h",
                            MEM_ADDR, MEM_WE, MEM_BE, MEM_WDATA, fr.addr, fr.we, fr.be, fr.wdata); end
                end
            end
            mack   = busy_exp && (wc - 1 == lat);
            to_now = busy_exp && !mack && (wc == TO + 1);
            rd = fix_en ? fix_rd : $urandom;
            MEM_ACK = mack;
            MEM_RDATA = mack ? rd : $urandom;
            drive_reqs();
            ir = IF_REQ; dr = D_REQ;
            #1;
            done = mack || to_now;
            vecs++; if (IF_ACK !== (done && !owner) || D_ACK !== (done && owner))
                begin errs++; $display("FAIL ack: IF_ACK=%0b D_ACK=%0b expected %0b/%0b",
                    IF_ACK, D_ACK, done && !owner, done && owner); end
            if (done) begin
                rexp = mack ? rd : 32'h0;
                vecs++; if (IF_RDATA !== rexp || D_RDATA !== rexp)
                    begin errs++; $display("FAIL rdata: IF=%h D=%h expected %h", IF_RDATA, D_RDATA, rexp); end
                ack_log.push_back('{owner, rexp, wc});
                if (owner && d_q.size() != 0) void'(d_q.pop_front());
                if (!owner && if_q.size() != 0) void'(if_q.pop_front());
                if (to_now) err_exp = 1'b1;
                busy_exp = 0;
            end else if (!busy_exp && (ir || dr)) begin
                owner = arb(ir, dr); last_win = owner; busy_exp = 1; wc = 0;
            end
            if (idx < gen_cyc) begin
                if (if_q.size() < 3 && $urandom_range(0, 99) < gen_pct) push_if($urandom & 32'hFFFF_FFFC);
                if (d_q.size() < 3 && $urandom_range(0, 99) < gen_pct)
                    push_d($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom);
            end
            if (idx >= gen_cyc && !busy_exp && if_q.size() == 0 && d_q.size() == 0) finished = 1;
        end
        if (!finished) begin
            vecs++; errs++; $display("FAIL drain: transactions still pending after %0d cycles", max_cyc);
        end
        MEM_ACK = 0; IF_REQ = 0; D_REQ = 0;
    endtask

    task automatic test_reset();
        @(posedge CLK); #1;
        RST = 1; IF_REQ = 1; D_REQ = 1; D_WE = 1; D_BE = 4'hF; IF_ADDR = $urandom; D_ADDR = $urandom;
        D_WDATA = $urandom; MEM_ACK = 1; MEM_RDATA = $urandom;
        @(posedge CLK); #1;
        vecs++; if ({MEM_REQ, BUSY, GNT_SEL, ERR, IF_ACK, D_ACK, MEM_WE} !== 7'b0)
            begin errs++; $display("FAIL reset_ctl: got %b expected 0", {MEM_REQ, BUSY, GNT_SEL, ERR, IF_ACK, D_ACK, MEM_WE}); end
        vecs++; if (MEM_BE !== 4'h0 || MEM_ADDR !== 32'h0 || MEM_WDATA !== 32'h0)
            begin errs++; $display("FAIL reset_mem: be=%h a=%h wd=%h expected 0", MEM_BE, MEM_ADDR, MEM_WDATA); end
        vecs++; if (IF_RDATA !== 32'h0 || D_RDATA !== 32'h0)
            begin errs++; $display("FAIL reset_rdata: IF=%h D=%h expected 0", IF_RDATA, D_RDATA); end
        RST = 0; IF_REQ = 0; D_REQ = 0; MEM_ACK = 0;
        last_win = 1'b1; err_exp = 1'b0;
    endtask

    task automatic test_if_read();
        do_reset();
        push_if(32'h100);
        run(40, 3, 0, 0, 1, 32'hDEADBEEF);
        vecs++; if (ack_log.size() != 1 || grant_log.size() != 1)
            begin errs++; $display("FAIL if_read_count: acks=%0d grants=%0d expected 1/1", ack_log.size(), grant_log.size()); end
        else begin
            vecs++; if (ack_log[0].owner !== 1'b0 || ack_log[0].rdata !== 32'hDEADBEEF || ack_log[0].wc != 4)
                begin errs++; $display("FAIL if_read: owner=%0b rdata=%h wcyc=%0d expected 0/deadbeef/4",
                    ack_log[0].owner, ack_log[0].rdata, ack_log[0].wc); end
        end
    endtask

    task automatic test_contest();
        bit exp_seq[$];
        do_reset();
        push_if(32'h300);
        push_d(32'h2000, 1'b1, 4'b0011, 32'h55AA);
        run(40, -1, 0, 0, 0, 0);
`ifdef OTTER_ARB_RR_EN
        exp_seq = '{1'b0, 1'b1};
`else
        exp_seq = '{1'b1, 1'b0};
`endif
        vecs++; if (grant_log != exp_seq)
            begin errs++; $display("FAIL contest_order: got %p expected %p", grant_log, exp_seq); end
    endtask

    task automatic test_back_to_back();
        bit exp_seq[$];
        do_reset();
        for (int i = 0; i < 3; i++) push_d(32'h4000 + 4 * i, 1'b1, 4'hF, 32'h1000 + i);
        push_if(32'h10); push_if(32'h14);
        run(80, -1, 0, 0, 0, 0);
`ifdef OTTER_ARB_RR_EN
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        vecs++; if (grant_log != exp_seq)
            begin errs++; $display("FAIL b2b_order: got %p expected %p", grant_log, exp_seq); end
    endtask

    task automatic test_timeout();
        do_reset();
        push_if(32'h500);
        run(40, 99, 0, 0, 0, 0);
        vecs++; if (ack_log.size() != 1)
            begin errs++; $display("FAIL timeout_count: acks=%0d expected 1", ack_log.size()); end
        else begin
            vecs++; if (ack_log[0].rdata !== 32'h0 || ack_log[0].wc != TO + 1)
                begin errs++; $display("FAIL timeout_ack: rdata=%h wcyc=%0d expected 0/%0d",
                    ack_log[0].rdata, ack_log[0].wc, TO + 1); end
        end
        @(posedge CLK); #1;
        MEM_ACK = 1; MEM_RDATA = 32'h12345678;
        #1;
        vecs++; if (IF_ACK !== 1'b0 || D_ACK !== 1'b0 || ERR !== 1'b1)
            begin errs++; $display("FAIL late_ack: IF_ACK=%0b D_ACK=%0b ERR=%0b expected 0/0/1", IF_ACK, D_ACK, ERR); end
        @(posedge CLK); #1;
        MEM_ACK = 0;
        vecs++; if (ERR !== 1'b1 || MEM_REQ !== 1'b0)
            begin errs++; $display("FAIL err_sticky: ERR=%0b MEM_REQ=%0b expected 1/0", ERR, MEM_REQ); end
    endtask

    task automatic test_reset_mid_wait();
        @(posedge CLK); #1;
        IF_REQ = 1; IF_ADDR = 32'h40;
        @(posedge CLK); #1;
        vecs++; if (MEM_REQ !== 1'b1)
            begin errs++; $display("FAIL rmw_grant: MEM_REQ=%0b expected 1", MEM_REQ); end
        @(posedge CLK); #1;
        RST = 1; MEM_ACK = 1; MEM_RDATA = 32'h1234;
        #1;
        vecs++; if (IF_ACK !== 1'b0 || D_ACK !== 1'b0)
            begin errs++; $display("FAIL rmw_noack: IF_ACK=%0b D_ACK=%0b expected 0", IF_ACK, D_ACK); end
        @(posedge CLK); #1;
        RST = 0; MEM_ACK = 0;
        vecs++; if (MEM_REQ !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b0 || IF_ACK !== 1'b0)
            begin errs++; $display("FAIL rmw_idle: MEM_REQ=%0b BUSY=%0b ERR=%0b IF_ACK=%0b expected 0",
                MEM_REQ, BUSY, ERR, IF_ACK); end
        @(posedge CLK); #1;
        vecs++; if (MEM_REQ !== 1'b1 || GNT_SEL !== 1'b0 || MEM_ADDR !== 32'h40)
            begin errs++; $display("FAIL rmw_regrant: MEM_REQ=%0b GNT_SEL=%0b a=%h expected 1/0/40",
                MEM_REQ, GNT_SEL, MEM_ADDR); end
        MEM_ACK = 1; MEM_RDATA = 32'hCAFE0001;
        #1;
        vecs++; if (IF_ACK !== 1'b1 || IF_RDATA !== 32'hCAFE0001)
            begin errs++; $display("FAIL rmw_done: IF_ACK=%0b rdata=%h expected 1/cafe0001", IF_ACK, IF_RDATA); end
        @(posedge CLK); #1;
        IF_REQ = 0; MEM_ACK = 0;
        last_win = 1'b0; err_exp = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        run(8000, -1, 35, 2500, 0, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_if_read();
        test_contest();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/otter_mem_arbiter.md
# otter_mem_arbiter

Two-port to one-port memory arbiter for the single-memory OTTER configuration. Shares one multi-cycle memory port between instruction fetch (IF) and data (D) requesters: selects a winner, latches its request, holds the memory handshake until acknowledged, and returns the acknowledge to the owner. Sits between the pipeline's fetch/memory stages and the unified memory. Drives the 2:1 select that steers memory address/write data.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT_CYC`, 255: maximum cycles in WAIT before forced completion; range 1..255.

- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `IF_REQ` in 1: fetch request; held with `IF_ADDR` until `IF_ACK`.
- `IF_ADDR` in ADDR_W: fetch address.
- `IF_RDATA` out DATA_W: fetch read data, valid when `IF_ACK`.
- `IF_ACK` out 1: one-cycle completion pulse.
- `D_REQ`, `D_WE` in 1: data request; write enable.
- `D_BE` in 4: byte enables.
- `D_ADDR` in ADDR_W, `D_WDATA` in DATA_W: data address, write data.
- `D_RDATA` out DATA_W, `D_ACK` out 1: data read data, completion pulse.
- `MEM_REQ`, `MEM_WE` out 1; `MEM_BE` out 4: memory request, write enable, byte enables.
- `MEM_ADDR` out ADDR_W, `MEM_WDATA` out DATA_W: memory address, write data.
- `MEM_RDATA` in DATA_W, `MEM_ACK` in 1: memory response; `MEM_ACK` is a one-cycle pulse.
- `GNT_SEL` out 1: current owner; 0 = IF, 1 = D.
- `BUSY` out 1: high in WAIT.
- `ERR` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, WAIT.
- IDLE, no request: stay in IDLE.
- IDLE, any request: pick a winner and register `GNT_SEL`. Latch the winner's ADDR/WE/BE/WDATA; IF is a read with BE=4'hF. Clear the timeout counter and go to WAIT.
- Arbitration default: D beats IF when both request.
- WAIT: `MEM_REQ`=1 and the latched fields drive the MEM_* outputs.
- WAIT, `MEM_ACK`=1: pulse the owner's ACK in the same cycle (combinational from `MEM_ACK`); return to IDLE.
- WAIT, no ack: increment the counter.
- Timeout: when the counter reaches `TIMEOUT_CYC`, pulse the owner's ACK with RDATA forced to 0, set `ERR`, return to IDLE. A late `MEM_ACK` after this is ignored.
- `IF_RDATA` and `D_RDATA` both carry `MEM_RDATA`, or 0 on a timeout ack. Only the owner's ACK pulses.
- Requester rule: in the cycle after its ACK, a requester either drops REQ or presents its next request. REQ seen in IDLE is always treated as new.
- A non-owner's REQ is ignored during WAIT and stays pending.
- `MEM_ACK` in IDLE is ignored.

## Timing
- Reset values: state IDLE; all outputs 0 (`MEM_REQ`, `IF_ACK`, `D_ACK`, `GNT_SEL`, `BUSY`, `ERR`, MEM_* fields, RDATA outputs).
- Latency: REQ sampled in cycle 0 → `MEM_REQ` in cycle 1. A same-cycle `MEM_ACK` gives ACK in cycle 1.
- Minimum 2 cycles per transaction, since one IDLE cycle separates grants.
- `RST` mid-WAIT: IDLE next cycle, `MEM_REQ` drops, no ACK issued, `ERR` cleared. Any in-flight memory response is dropped.
- Timeout counter is 8 bits and saturates; no wrap.

## Configuration
- `OTTER_ARB_RR_EN` defined: round-robin arbitration. A last-owner register is updated on each grant; on a simultaneous request the port that did not win last gets priority. Reset last-owner = D, so IF wins the first contest.
- Undefined: fixed priority, D over IF. No last-owner register.

## Structure
- Package `otter_arb_pkg` holds:
  - the state enum (IDLE, WAIT);
  - `PORT_IF`=1'b0, `PORT_D`=1'b1;
  - the default timeout constant.
- Address and write-data steering uses an instance of the existing `Mult2to1`, selected by the IDLE-cycle winner, feeding the latch registers.
- No other sub-modules.

## Test plan
- Only IF requests 0x100, memory acks 3 cycles after `MEM_REQ` with 0xDEADBEEF → `IF_ACK` pulses once, `IF_RDATA`=0xDEADBEEF, `GNT_SEL`=0, `MEM_WE`=0, `MEM_BE`=4'hF.
- IF and D request in the same cycle, D write 0x55AA to 0x2000, BE=4'b0011 → without macro: D served first (`MEM_WE`=1, `MEM_BE`=4'b0011), then IF. With macro: IF first on the first contest, D on the next.
- D held continuously with back-to-back requests while IF requests, macro on → grants alternate D, IF, D; IF never waits more than one transaction.
- Memory never acks, `TIMEOUT_CYC`=4 → owner ACK in the 5th WAIT cycle with RDATA=0, `ERR`=1 and sticky; a later `MEM_ACK` in IDLE produces no ACK.
- `RST` asserted on the 2nd WAIT cycle → next cycle `MEM_REQ`=0, `BUSY`=0, `ERR`=0, no ACK; a pending REQ is granted after `RST` falls.
